// File: rtl/frng_xchg_sched.sv
`default_nettype none
// ============================================================================
// Module   : frng_xchg_sched
// Purpose  : Collects mission-clock edges into per-row pending flags and data
//            snapshots, freezes each clock while its row is outstanding, and
//            issues the rows one at a time to a put socket with retry and
//            watchdog handling.
// Revision : 1.0 - initial release
// ============================================================================
module frng_xchg_sched #(
    parameter int N_CLK     = 4,
    parameter int DATA_W    = 9,
    parameter int WDOG_MAX  = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_CLK-1:0]          clk_edge_i,
    input  logic [N_CLK-1:0]          row_mask_i,
    input  logic [N_CLK*DATA_W-1:0]   row_data_i,
    output logic [N_CLK-1:0]          freeze_clk_o,
    output logic                      put_req_o,
    output logic [$clog2(N_CLK)-1:0]  put_id_o,
    output logic [DATA_W-1:0]         put_data_o,
    input  logic                      put_ack_i,
    input  logic                      put_err_i,
    output logic                      busy_o,
    output logic                      overrun_o,
    output logic                      timeout_o,
    output logic [15:0]               xfer_cnt_o
);

    localparam int c_IDW = $clog2(N_CLK);
    localparam int c_WW  = $clog2(WDOG_MAX + 1);
    localparam int c_RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_REQ   = 2'd1;
    localparam logic [1:0] c_RETRY = 2'd2;

    logic [1:0]        r_state;
    logic [N_CLK-1:0]  r_pending;
    logic [DATA_W-1:0] r_snap [N_CLK];
    logic              r_put_req;
    logic [c_IDW-1:0]  r_put_id;
    logic [DATA_W-1:0] r_put_data;
    logic [c_RW-1:0]   r_retry;
    logic [c_WW-1:0]   r_wdog;
    logic              r_overrun;
    logic              r_timeout;
    logic [15:0]       r_xfer;

    logic              w_in_req;
    logic              w_ok;
    logic              w_err_drop;
    logic              w_wdog_exp;
    logic              w_release;
    logic [N_CLK-1:0]  w_clr;
    logic [N_CLK-1:0]  w_edge;
    logic [c_IDW-1:0]  w_sel;

    assign w_in_req   = (r_state == c_REQ);
    assign w_ok       = w_in_req & put_ack_i & ~put_err_i;
    assign w_err_drop = w_in_req & put_ack_i & put_err_i & (r_retry == c_RW'(MAX_RETRY));
    assign w_wdog_exp = w_in_req & ~put_ack_i & (r_wdog == c_WW'(WDOG_MAX - 1));
    assign w_release  = w_ok | w_err_drop | w_wdog_exp;
    assign w_clr      = w_release ? (N_CLK'(1) << r_put_id) : '0;
    assign w_edge     = clk_edge_i & ~row_mask_i;

    // Lowest index wins: scan downward so the last hit is the smallest row.
    always_comb begin
        w_sel = '0;
        for (int i = N_CLK - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = c_IDW'(i);
            end
        end
    end

    // A row being released this cycle accepts a fresh edge (clear-then-set)
    // instead of flagging it as an overrun.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < N_CLK; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CLK; i++) begin
                if (w_edge[i] && (!r_pending[i] || w_clr[i])) begin
                    r_pending[i] <= 1'b1;
                    r_snap[i]    <= row_data_i[i*DATA_W +: DATA_W];
                end else if (w_clr[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
            if (|(w_edge & r_pending & ~w_clr)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= c_IDLE;
            r_put_req  <= 1'b0;
            r_put_id   <= '0;
            r_put_data <= '0;
            r_retry    <= '0;
            r_wdog     <= '0;
            r_timeout  <= 1'b0;
            r_xfer     <= 16'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (|r_pending) begin
                        r_put_id   <= w_sel;
                        r_put_data <= r_snap[w_sel];
                        r_put_req  <= 1'b1;
                        r_wdog     <= '0;
                        r_state    <= c_REQ;
                    end
                end
                c_REQ: begin
                    if (put_ack_i) begin
                        r_put_req <= 1'b0;
                        if (!put_err_i) begin
                            r_xfer  <= r_xfer + 16'd1;
                            r_retry <= '0;
                            r_state <= c_IDLE;
                        end else if (w_err_drop) begin
                            r_timeout <= 1'b1;
                            r_retry   <= '0;
                            r_state   <= c_IDLE;
                        end else begin
                            r_retry <= r_retry + c_RW'(1);
                            r_state <= c_RETRY;
                        end
                    end else if (w_wdog_exp) begin
                        r_put_req <= 1'b0;
                        r_timeout <= 1'b1;
                        r_retry   <= '0;
                        r_state   <= c_IDLE;
                    end else begin
                        r_wdog <= r_wdog + c_WW'(1);
                    end
                end
                c_RETRY: begin
                    r_put_req <= 1'b1;
                    r_wdog    <= '0;
                    r_state   <= c_REQ;
                end
                default: begin
                    r_put_req <= 1'b0;
                    r_state   <= c_IDLE;
                end
            endcase
        end
    end

    assign freeze_clk_o = r_pending;
    assign put_req_o    = r_put_req;
    assign put_id_o     = r_put_id;
    assign put_data_o   = r_put_data;
    assign busy_o       = (r_state != c_IDLE);
    assign overrun_o    = r_overrun;
    assign timeout_o    = r_timeout;
    assign xfer_cnt_o   = r_xfer;

endmodule
`default_nettype wire

// File: tb/tb_frng_xchg_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_frng_xchg_sched
// Purpose  : Directed, scoreboard-based self-checking bench for frng_xchg_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frng_xchg_sched;

    localparam int N_CLK     = 4;
    localparam int DATA_W    = 9;
    localparam int WDOG_MAX  = 255;
    localparam int MAX_RETRY = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [N_CLK-1:0]        clk_edge = '0;
    logic [N_CLK-1:0]        row_mask = '0;
    logic [N_CLK*DATA_W-1:0] row_data = '0;
    logic [N_CLK-1:0]        freeze_clk;
    logic                    put_req;
    logic [1:0]              put_id;
    logic [DATA_W-1:0]       put_data;
    logic                    put_ack = 1'b0;
    logic                    put_err = 1'b0;
    logic                    busy;
    logic                    overrun;
    logic                    timeout;
    logic [15:0]             xfer_cnt;

    typedef struct packed {
        logic [1:0]        id;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   exp_xfer  = 0;

    frng_xchg_sched #(
        .N_CLK     (N_CLK),
        .DATA_W    (DATA_W),
        .WDOG_MAX  (WDOG_MAX),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clk_edge_i   (clk_edge),
        .row_mask_i   (row_mask),
        .row_data_i   (row_data),
        .freeze_clk_o (freeze_clk),
        .put_req_o    (put_req),
        .put_id_o     (put_id),
        .put_data_o   (put_data),
        .put_ack_i    (put_ack),
        .put_err_i    (put_err),
        .busy_o       (busy),
        .overrun_o    (overrun),
        .timeout_o    (timeout),
        .xfer_cnt_o   (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_row(input int r, input logic [DATA_W-1:0] d);
        row_data[r*DATA_W +: DATA_W] = d;
    endtask

    task automatic push(input logic [1:0] id, input logic [DATA_W-1:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_req();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (put_req === 1'b1) seen = 1'b1;
            else tick();
        end
        chk("req_seen", 64'(seen), 64'd1);
    endtask

    // Current cycle has put_req high; compare against scoreboard, then accept.
    task automatic ack_ok();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk("put_id", 64'(put_id), 64'(e.id));
            chk("put_data", 64'(put_data), 64'(e.data));
        end
        put_ack = 1'b1;
        put_err = 1'b0;
        tick();
        put_ack = 1'b0;
        exp_xfer++;
        chk("req_low_after_ack", 64'(put_req), 64'd0);
        chk("xfer_cnt", 64'(xfer_cnt), 64'(exp_xfer));
    endtask

    task automatic do_reset();
        clk_edge = '0;
        row_mask = '0;
        put_ack  = 1'b0;
        put_err  = 1'b0;
        rst      = 1'b1;
        tick();
        chk("rst_freeze", 64'(freeze_clk), 64'd0);
        chk("rst_req", 64'(put_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_flags", 64'({overrun, timeout}), 64'd0);
        chk("rst_xfer", 64'(xfer_cnt), 64'd0);
        rst = 1'b0;
        sb.delete();
        exp_xfer = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        logic [N_CLK-1:0] expf;
        logic [1:0]       id;
        int               cnt;

        do_reset();

        // Single edge on row 2, ack on the third request cycle.
        clk_edge = 4'b0100;
        set_row(2, 9'h1A5);
        push(2'd2, 9'h1A5);
        tick();
        clk_edge = '0;
        chk("t1_freeze_t1", 64'(freeze_clk), 64'b0100);
        chk("t1_req_t1", 64'(put_req), 64'd0);
        tick();
        chk("t1_req_t2", 64'(put_req), 64'd1);
        tick();
        chk("t1_req_t3", 64'(put_req), 64'd1);
        tick();
        chk("t1_freeze_t4", 64'(freeze_clk), 64'b0100);
        ack_ok();
        chk("t1_freeze_t5", 64'(freeze_clk), 64'd0);
        chk("t1_busy_t5", 64'(busy), 64'd0);

        // Three rows in one cycle, served lowest index first.
        clk_edge = 4'b1011;
        set_row(0, 9'h011);
        set_row(1, 9'h022);
        set_row(3, 9'h033);
        push(2'd0, 9'h011);
        push(2'd1, 9'h022);
        push(2'd3, 9'h033);
        tick();
        clk_edge = '0;
        expf = 4'b1011;
        chk("t2_freeze", 64'(freeze_clk), 64'(expf));
        for (int n = 0; n < 3; n++) begin
            wait_req();
            id = sb[0].id;
            ack_ok();
            expf[id] = 1'b0;
            chk("t2_freeze_release", 64'(freeze_clk), 64'(expf));
        end

        // Four error acks on row 1: three retries then a drop.
        clk_edge = 4'b0010;
        set_row(1, 9'h0C3);
        tick();
        clk_edge = '0;
        wait_req();
        chk("t3_id", 64'(put_id), 64'd1);
        for (int k = 0; k < 4; k++) begin
            put_ack = 1'b1;
            put_err = 1'b1;
            tick();
            put_ack = 1'b0;
            put_err = 1'b0;
            chk("t3_req_low", 64'(put_req), 64'd0);
            if (k < 3) begin
                chk("t3_no_timeout_yet", 64'(timeout), 64'd0);
                tick();
                chk("t3_reissue", 64'(put_req), 64'd1);
                chk("t3_data", 64'(put_data), 64'h0C3);
            end
        end
        chk("t3_timeout", 64'(timeout), 64'd1);
        chk("t3_freeze", 64'(freeze_clk), 64'd0);
        chk("t3_xfer", 64'(xfer_cnt), 64'(exp_xfer));
        chk("t3_busy", 64'(busy), 64'd0);

        // Watchdog: row 0 never acknowledged.
        do_reset();
        clk_edge = 4'b0001;
        set_row(0, 9'h07E);
        tick();
        clk_edge = '0;
        wait_req();
        cnt = 0;
        while (put_req === 1'b1 && cnt < 400) begin
            cnt++;
            tick();
        end
        chk("t4_wdog_len", 64'(cnt), 64'(WDOG_MAX));
        chk("t4_timeout", 64'(timeout), 64'd1);
        chk("t4_freeze", 64'(freeze_clk), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);

        // New edge on row 0 coincident with its successful ack.
        do_reset();
        clk_edge = 4'b0001;
        set_row(0, 9'h0F0);
        push(2'd0, 9'h0F0);
        tick();
        clk_edge = '0;
        wait_req();
        clk_edge = 4'b0001;
        set_row(0, 9'h10F);
        ack_ok();
        clk_edge = '0;
        push(2'd0, 9'h10F);
        chk("t5_freeze_kept", 64'(freeze_clk), 64'b0001);
        chk("t5_no_overrun", 64'(overrun), 64'd0);
        wait_req();
        ack_ok();
        chk("t5_freeze_clear", 64'(freeze_clk), 64'd0);

        // Overrun on row 3, masked row 2, mask rising on an outstanding row.
        do_reset();
        row_mask = 4'b0100;
        clk_edge = 4'b1100;
        set_row(3, 9'h0AA);
        set_row(2, 9'h155);
        push(2'd3, 9'h0AA);
        tick();
        clk_edge = 4'b1000;
        set_row(3, 9'h1FF);
        tick();
        clk_edge = '0;
        chk("t6_overrun", 64'(overrun), 64'd1);
        chk("t6_freeze", 64'(freeze_clk), 64'b1000);
        row_mask = 4'b1100;
        wait_req();
        ack_ok();
        chk("t6_freeze_clear", 64'(freeze_clk), 64'd0);
        cnt = 0;
        repeat (6) begin
            tick();
            if (put_req === 1'b1) cnt++;
        end
        chk("t6_no_extra_put", 64'(cnt), 64'd0);
        row_mask = '0;
        put_ack  = 1'b1;
        tick();
        put_ack  = 1'b0;
        tick();
        chk("t6_stray_ack_xfer", 64'(xfer_cnt), 64'(exp_xfer));
        chk("t6_stray_ack_busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a put, then normal resume.
        clk_edge = 4'b0010;
        set_row(1, 9'h111);
        tick();
        clk_edge = '0;
        wait_req();
        #2;
        rst = 1'b1;
        #1;
        chk("t7_async_req", 64'(put_req), 64'd0);
        chk("t7_async_freeze", 64'(freeze_clk), 64'd0);
        chk("t7_async_busy", 64'(busy), 64'd0);
        chk("t7_async_xfer", 64'(xfer_cnt), 64'd0);
        chk("t7_async_flags", 64'({overrun, timeout}), 64'd0);
        chk("t7_async_put", 64'({put_id, put_data}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_xfer = 0;
        clk_edge = 4'b0001;
        set_row(0, 9'h0D4);
        push(2'd0, 9'h0D4);
        tick();
        clk_edge = '0;
        chk("t7_req_t1", 64'(put_req), 64'd0);
        chk("t7_freeze_t1", 64'(freeze_clk), 64'b0001);
        tick();
        chk("t7_req_t2", 64'(put_req), 64'd1);
        ack_ok();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
